aes_spi_scheduler: RTL and testbench
====================================

# aes_spi_scheduler

Shares the single serial AES slave between two requesters. It arbitrates round-robin and latches the winner's message, key and mode. It then runs one complete SPI transaction: message out, key out, processing gap, 128-bit result in. The result goes back with a one-cycle acknowledge. It sits between the top-level control logic and the AES slave and replaces hand-sequenced MOSI/CS driving.

## Interface
- NK, 4, key length in 32-bit words (key = 32*NK bits)
- CLK_DIV, 256, clk cycles per SCLK half-period (≥1)
- LAT_BITS, 2, idle bit periods between last key bit and first result bit
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req0, req1  in  1  transaction request; held high until matching ack
- mode0, mode1  in  1  0 = encrypt, 1 = decrypt
- data0, data1  in  128  plaintext/ciphertext block
- key0, key1  in  32*NK  cipher key
- gnt  out  2  one-hot owner of the current transaction, 00 when idle
- ack0, ack1  out  1  one-clk pulse, result valid for that requester
- result  out  128  last received block, held until next transaction completes
- busy  out  1  high from grant through ack
- sclk  out  1  serial clock to slave
- cs  out  1  active-low select to slave
- mosi  out  1  serial data to slave
- mode  out  1  mode of current transaction to slave
- miso  in  1  serial data from slave

## Operation
- Reset values: gnt=00, ack0=ack1=0, result=0, busy=0, sclk=0, cs=1, mosi=0, mode=0; FSM IDLE; rr pointer = "1 last served".
- FSM: IDLE → LOAD → TX_MSG → TX_KEY → WAIT → RX → DONE → IDLE.
- IDLE: if any req, pick winner.
  - Both high: the one not served last wins.
  - Only one high: that one wins.
  - Go to LOAD.
- LOAD (1 clk): latch data, key and mode of the winner. Set gnt, busy=1, cs=0, mode. Clear divider and bit counter.
- Divider: counts 0..CLK_DIV-1. On terminal count sclk toggles. Bit period = 2*CLK_DIV clk.
  - Falling edge of sclk = "shift" event.
  - Rising edge of sclk = "sample" event.
- TX_MSG: 128 bits, LSB first (data[0] first). mosi updates on shift event.
- TX_KEY: 32*NK bits, key[0] first.
- WAIT: LAT_BITS bit periods, mosi=0, cs stays 0.
- RX: 128 sample events. result_sr <= {miso, result_sr[127:1]}, so the first bit received lands in result[0].
- DONE: cs=1 for one bit period. Then copy result_sr to result, pulse ack of the owner for 1 clk, clear gnt/busy, update the rr pointer, go to IDLE.
- req dropped mid-transaction: the transaction completes anyway and ack still pulses. Requester inputs change after LOAD: ignored.
- New request in the ack cycle: not granted before the next IDLE cycle.
- Reset asserted mid-transaction: all outputs return to reset values immediately (cs=1 asynchronously). Partial result is discarded and result is cleared to 0.

## Timing
- Grant: gnt/busy rise 1 clk after req is sampled in IDLE.
- Transaction length from the first cycle gnt is high to the ack pulse: 1 + 2*CLK_DIV*(257 + 32*NK + LAT_BITS) clk.
  - Breakdown: 128 msg + 32*NK key + LAT_BITS + 128 rx + 1 DONE bit periods, plus 1 clk.
- mosi stable for one full bit period around each sampling edge. Slave samples on sclk rise.
- result updates in the same cycle ack pulses and is stable afterwards.
- Back-to-back: minimum 1 IDLE clk between ack and the next gnt.
- sclk idles low whenever cs=1.

## Test plan
- Single encrypt, CLK_DIV=2, LAT_BITS=2, NK=4: req0, data0=3243f6a8885a308d313198a2e0370734, key0=2b7e151628aed2a6abf7158809cf4f3c, slave model → 128 bits on mosi match data0 LSB first, then 128 key bits. ack0 pulses exactly 1549 clk after gnt=01. result=3925841d02dc09fbdc118597196a0b32.
- Simultaneous req0 and req1 from reset → gnt=01 first, ack0. Then gnt=10, ack1 with req0 still high. Then gnt=01 again (round robin).
- Decrypt via requester 1: mode1=1, data1=3925841d02dc09fbdc118597196a0b32 → mode=1 throughout, result=3243f6a8885a308d313198a2e0370734, ack1 only.
- Reset pulsed in RX phase → cs=1, sclk=0, busy=0, gnt=00, result=0 at once. A fresh req0 afterwards completes normally.
- req0 dropped and data0 changed after LOAD → bits on mosi equal the originally latched values. ack0 still pulses.
- Idle check: no req for 1000 clk → cs=1, sclk=0, mosi=0, no ack.

Source files
------------

// File: rtl/aes_spi_scheduler.sv
// Two-requester front end for a serial AES slave: round-robin grant, then one
// full SPI exchange (message, key, latency gap, 128-bit result) per grant.
module aes_spi_scheduler #(
  parameter int NK       = 4,
  parameter int CLK_DIV  = 256,
  parameter int LAT_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             mode0,
  input  logic             mode1,
  input  logic [127:0]     data0,
  input  logic [127:0]     data1,
  input  logic [32*NK-1:0] key0,
  input  logic [32*NK-1:0] key1,
  output logic [1:0]       gnt,
  output logic             ack0,
  output logic             ack1,
  output logic [127:0]     result,
  output logic             busy,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  output logic             mode,
  input  logic             miso
);

  localparam int KW    = 32 * NK;
  localparam int TXW   = 128 + KW;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = 16;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(127);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KW - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_BITS - 1);
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(127);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TX_MSG, S_TX_KEY, S_WAIT, S_RX, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic [127:0]       result_q, result_d;
  logic               busy_q, busy_d;
  logic               sclk_q, sclk_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;
  logic               mode_q, mode_d;
  logic               last_q, last_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               half_q, half_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TXW-1:0]     tx_sr_q, tx_sr_d;
  logic [127:0]       rx_sr_q, rx_sr_d;

  logic tc;
  logic bit_end;
  logic pick1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    result_d = result_q;
    busy_d   = busy_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    mosi_d   = mosi_q;
    mode_d   = mode_q;
    last_d   = last_q;
    div_d    = div_q;
    half_d   = half_q;
    cnt_d    = cnt_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;

    tc      = (div_q == DIV_LAST);
    bit_end = tc && half_q;
    // Requester 1 wins when alone, or when both ask and 0 was served last.
    pick1   = req1 && (!req0 || !last_q);

    // Bit-period timebase: low half then high half; the rise samples, the fall shifts.
    if (state_q inside {S_TX_MSG, S_TX_KEY, S_WAIT, S_RX, S_DONE}) begin
      div_d = tc ? '0 : div_q + DIV_W'(1);
      if (tc) begin
        half_d = ~half_q;
        sclk_d = (state_q == S_DONE) ? 1'b0 : ~half_q;
      end
      if (bit_end) cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        // The ack cycle never grants, so a stale request cannot be re-served.
        if (!ack0_q && !ack1_q && (req0 || req1)) begin
          state_d = S_LOAD;
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          mode_d  = pick1 ? mode1 : mode0;
          tx_sr_d = pick1 ? {key1, data1} : {key0, data0};
        end
      end
      S_LOAD: begin
        div_d   = '0;
        half_d  = 1'b0;
        cnt_d   = '0;
        sclk_d  = 1'b0;
        mosi_d  = tx_sr_q[0];
        tx_sr_d = tx_sr_q >> 1;
        state_d = S_TX_MSG;
      end
      S_TX_MSG: begin
        if (bit_end) begin
          mosi_d  = tx_sr_q[0];
          tx_sr_d = tx_sr_q >> 1;
          if (cnt_q == MSG_LAST) begin
            cnt_d   = '0;
            state_d = S_TX_KEY;
          end
        end
      end
      S_TX_KEY: begin
        if (bit_end) begin
          if (cnt_q == KEY_LAST) begin
            mosi_d  = 1'b0;
            cnt_d   = '0;
            state_d = (LAT_BITS == 0) ? S_RX : S_WAIT;
          end else begin
            mosi_d  = tx_sr_q[0];
            tx_sr_d = tx_sr_q >> 1;
          end
        end
      end
      S_WAIT: begin
        if (bit_end && (cnt_q == LAT_LAST)) begin
          cnt_d   = '0;
          state_d = S_RX;
        end
      end
      S_RX: begin
        if (tc && !half_q) rx_sr_d = {miso, rx_sr_q[127:1]};
        if (bit_end && (cnt_q == RX_LAST)) begin
          cnt_d   = '0;
          cs_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bit_end) begin
          state_d  = S_IDLE;
          result_d = rx_sr_q;
          ack0_d   = gnt_q[0];
          ack1_d   = gnt_q[1];
          last_d   = gnt_q[1];
          gnt_d    = 2'b00;
          busy_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gnt_q    <= 2'b00;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      mode_q   <= 1'b0;
      last_q   <= 1'b1;
      div_q    <= '0;
      half_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      mode_q   <= mode_d;
      last_q   <= last_d;
      div_q    <= div_d;
      half_q   <= half_d;
      cnt_q    <= cnt_d;
    end
  end

  // Shift registers carry only data; every transaction fully rewrites them.
  always_ff @(posedge clk) begin
    tx_sr_q <= tx_sr_d;
    rx_sr_q <= rx_sr_d;
  end

  assign gnt    = gnt_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign sclk   = sclk_q;
  assign cs     = cs_q;
  assign mosi   = mosi_q;
  assign mode   = mode_q;

endmodule

// File: tb/tb_aes_spi_scheduler.sv
// Scoreboard bench for aes_spi_scheduler with a behavioural SPI AES slave.
`timescale 1ns/1ps
module tb_aes_spi_scheduler;

  localparam int NK       = 4;
  localparam int CLK_DIV  = 2;
  localparam int LAT_BITS = 2;
  localparam int KW       = 32 * NK;
  localparam int TXN_LEN  = 1549;

  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] D0  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K0  = 128'hffffffff00000000ffffffff00000000;
  localparam logic [127:0] R0  = 128'hfedcba9889abcdef0123456776543210;
  localparam logic [127:0] D1  = 128'h00000000000000000000000000000001;
  localparam logic [127:0] K1  = 128'h80000000000000000000000000000000;
  localparam logic [127:0] R1  = 128'h80000000000000000000000000000001;
  localparam logic [127:0] D2  = 128'h000000000000000000000000000000ff;
  localparam logic [127:0] R2  = 128'hffffffff00000000ffffffff000000ff;

  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0, miso = 1'b0;
  logic [127:0] data0 = '0, data1 = '0;
  logic [KW-1:0] key0 = '0, key1 = '0;
  logic [1:0] gnt;
  logic ack0, ack1, busy, sclk, cs, mosi, mode;
  logic [127:0] result;

  aes_spi_scheduler #(.NK(NK), .CLK_DIV(CLK_DIV), .LAT_BITS(LAT_BITS)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .data0(data0), .data1(data1), .key0(key0), .key1(key1), .gnt(gnt), .ack0(ack0),
    .ack1(ack1), .result(result), .busy(busy), .sclk(sclk), .cs(cs), .mosi(mosi),
    .mode(mode), .miso(miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            who;
    logic [127:0]  res;
    logic [127:0]  msg;
    logic [KW-1:0] key;
    logic          md;
  } exp_t;

  exp_t sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Slave behaviour: the two known AES vectors, otherwise msg ^ key.
  function automatic logic [127:0] slave_fn(input logic [127:0] m, input logic [KW-1:0] k, input logic md);
    if (!md && m == PT && k == KEY) return CT;
    if (md && m == CT && k == KEY) return PT;
    return m ^ k;
  endfunction

  int rise_n = 0, fall_n = 0;
  logic [127:0] cap_msg = '0, resp = '0;
  logic [KW-1:0] cap_key = '0;
  logic cap_mode = 1'b0, mode_bad = 1'b0, sclk_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (cs) begin
        rise_n = 0;
        fall_n = 0;
        miso   = 1'b0;
      end else begin
        if (sclk && !sclk_prev) begin
          if (rise_n < 128) cap_msg[rise_n] = mosi;
          else if (rise_n < 128 + KW) cap_key[rise_n - 128] = mosi;
          if (rise_n == 0) begin
            cap_mode = mode;
            mode_bad = 1'b0;
          end else if (mode !== cap_mode) mode_bad = 1'b1;
          if (rise_n == 127 + KW) resp = slave_fn(cap_msg, cap_key, cap_mode);
          rise_n++;
        end
        if (!sclk && sclk_prev) begin
          fall_n++;
          if (fall_n >= 128 + KW + LAT_BITS && fall_n < 256 + KW + LAT_BITS)
            miso = resp[fall_n - (128 + KW + LAT_BITS)];
        end
      end
      sclk_prev = sclk;
    end
  end

  logic [1:0] gnt_prev = 2'b00, gnt_first = 2'b00;
  int mcyc = 0, gnt_at = 0;

  initial begin
    exp_t e;
    logic [1:0] onehot;
    forever begin
      @(negedge clk);
      mcyc++;
      if (gnt != 2'b00 && gnt_prev == 2'b00) begin
        gnt_at    = mcyc;
        gnt_first = gnt;
      end
      if (ack0 || ack1) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_ack: ack1,ack0=%b%b with nothing pending", ack1, ack0);
        end else begin
          e = sbq.pop_front();
          onehot = (e.who == 1) ? 2'b10 : 2'b01;
          check("ack_owner", {ack1, ack0}, onehot);
          check("gnt_owner", gnt_first, onehot);
          check("latency", mcyc - gnt_at, TXN_LEN);
          check("result", result, e.res);
          check("mosi_msg", cap_msg, e.msg);
          check("mosi_key", cap_key, e.key);
          check("mode_pin", {mode_bad, cap_mode}, {1'b0, e.md});
          check("released_at_ack", {busy, gnt}, 3'b000);
        end
      end
      gnt_prev = gnt;
    end
  end

  task automatic wait_ack(input int who, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2500 && !seen; i++) begin
      @(negedge clk);
      seen = (who == 0) ? ack0 : ack1;
    end
    check(name, seen, 1);
  endtask

  task automatic wait_gnt(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (gnt != 2'b00);
    end
    check(name, seen, 1);
  endtask

  initial begin
    bit idle_bad;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_ack", {ack1, ack0}, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_sclk", sclk, 0);
    check("rst_cs", cs, 1);
    check("rst_mosi", mosi, 0);
    check("rst_mode", mode, 0);
    reset = 1'b0;

    idle_bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (cs !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || ack0 || ack1 || busy) idle_bad = 1'b1;
    end
    check("idle_lines", idle_bad, 0);

    // Single encrypt via requester 0
    sbq.push_back('{who: 0, res: CT, msg: PT, key: KEY, md: 1'b0});
    data0 = PT; key0 = KEY; mode0 = 1'b0; req0 = 1'b1;
    wait_ack(0, "ack0_encrypt");
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    // Decrypt via requester 1
    sbq.push_back('{who: 1, res: PT, msg: CT, key: KEY, md: 1'b1});
    data1 = CT; key1 = KEY; mode1 = 1'b1; req1 = 1'b1;
    wait_ack(1, "ack1_decrypt");
    req1 = 1'b0; mode1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during the receive phase, then a fresh transaction
    data0 = PT; key0 = KEY; mode0 = 1'b0; req0 = 1'b1;
    wait_gnt("gnt_before_abort");
    repeat (1100) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_busy", busy, 0);
    check("abort_gnt", gnt, 0);
    check("abort_result", result, 0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sbq.push_back('{who: 0, res: CT, msg: PT, key: KEY, md: 1'b0});
    req0 = 1'b1;
    wait_ack(0, "ack0_after_abort");
    req0 = 1'b0;
    repeat (3) @(negedge clk);

    // Request dropped and inputs changed after the grant
    sbq.push_back('{who: 0, res: CT, msg: PT, key: KEY, md: 1'b0});
    data0 = PT; key0 = KEY; mode0 = 1'b0; req0 = 1'b1;
    wait_gnt("gnt_drop");
    repeat (3) @(negedge clk);
    req0 = 1'b0; data0 = ~PT; key0 = '0; mode0 = 1'b1;
    wait_ack(0, "ack0_after_drop");
    mode0 = 1'b0;
    repeat (3) @(negedge clk);

    // Round robin from reset with both requesters asking
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sbq.push_back('{who: 0, res: R0, msg: D0, key: K0, md: 1'b0});
    sbq.push_back('{who: 1, res: R1, msg: D1, key: K1, md: 1'b0});
    sbq.push_back('{who: 0, res: R2, msg: D2, key: K0, md: 1'b0});
    data0 = D0; key0 = K0; data1 = D1; key1 = K1; req0 = 1'b1; req1 = 1'b1;
    wait_ack(0, "rr_first_ack0");
    data0 = D2;
    wait_ack(1, "rr_ack1");
    req1 = 1'b0;
    wait_ack(0, "rr_second_ack0");
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
